// File: rtl/chip8_audio_pkg.sv
// Shared types and defaults for the CHIP-8 sound-timer controller.
package chip8_audio_pkg;

   localparam int unsigned ST_W           = 8;
   localparam int unsigned CTRL_W         = 4;
   localparam int unsigned CTRL_SINE      = 0;
   localparam int unsigned CTRL_FEEDBACK  = 1;
   localparam int unsigned SAMPLE_DIV_DEF = 1042;
   localparam int unsigned TICK_DIV_DEF   = 833333;
   localparam int unsigned TABLE_LEN_DEF  = 100;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TONE  = 2'd1,
      DRAIN = 2'd2
   } state_e;

   // Datapath control word; sine lands on bit CTRL_SINE, feedback on CTRL_FEEDBACK.
   typedef struct packed {
      logic [1:0] rsvd;
      logic       feedback;
      logic       sine;
   } ctrl_t;

endpackage

// File: rtl/chip8_sound_ctrl_if.sv
// CPU-side ST port plus controller outputs toward the audio datapath.
interface chip8_sound_ctrl_if;
   import chip8_audio_pkg::*;

   logic              st_wr;
   logic [ST_W-1:0]   st_wdata;
   logic [ST_W-1:0]   st_value;
   logic              sample_end;
   logic              sample_req;
   logic [CTRL_W-1:0] control;
   logic              tone_active;
   logic              tick_60hz;

   modport master (
      output st_wr, st_wdata,
      input  st_value, sample_end, sample_req, control, tone_active, tick_60hz
   );

   modport slave (
      input  st_wr, st_wdata,
      output st_value, sample_end, sample_req, control, tone_active, tick_60hz
   );

endinterface

// File: rtl/chip8_strobe_div.sv
// Free-running modulo-DIV counter with a registered one-cycle strobe while count == PULSE_AT.
module chip8_strobe_div #(
   parameter int unsigned DIV      = 8,
   parameter int unsigned PULSE_AT = 0
) (
   input  logic clk,
   input  logic reset_n,
   output logic o_pulse
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          r_pulse;

   assign w_cnt_nxt = (r_cnt == CW'(DIV - 1)) ? '0 : r_cnt + CW'(1);

   // Count and pre-decode the strobe so it is high exactly while r_cnt == PULSE_AT.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt   <= '0;
         r_pulse <= 1'b0;
      end else begin
         r_cnt   <= w_cnt_nxt;
         r_pulse <= (w_cnt_nxt == CW'(PULSE_AT));
      end
   end

   assign o_pulse = r_pulse;

endmodule

// File: rtl/chip8_sound_ctrl.sv
// CHIP-8 sound-timer controller: holds ST, paces the sine/feedback datapath and
// lets the tone finish at a sine-table wrap. Optional macro CHIP8_AUDIO_LOOPBACK_EN
// adds loopback_en, which selects feedback and mutes/freezes the sine path.
module chip8_sound_ctrl
   import chip8_audio_pkg::*;
#(
   parameter int unsigned SAMPLE_DIV = SAMPLE_DIV_DEF,
   parameter int unsigned TICK_DIV   = TICK_DIV_DEF,
   parameter int unsigned TABLE_LEN  = TABLE_LEN_DEF
) (
   input  logic clk,
   input  logic reset_n,
`ifdef CHIP8_AUDIO_LOOPBACK_EN
   input  logic loopback_en,
`endif
   chip8_sound_ctrl_if.slave bus
);

   localparam int unsigned PW = (TABLE_LEN > 1) ? $clog2(TABLE_LEN) : 1;

   logic            w_sample_end;
   logic            w_sample_req;
   logic            w_tick;
   logic            w_loopback;
   logic            w_phase_zero;
   logic [ST_W-1:0] w_st_nxt;
   logic [ST_W-1:0] r_st;
   logic [PW-1:0]   r_phase;
   state_e          r_state;
   ctrl_t           r_ctrl;
   logic            r_tone_active;

`ifdef CHIP8_AUDIO_LOOPBACK_EN
   assign w_loopback = loopback_en;
`else
   assign w_loopback = 1'b0;
`endif

   // Sample pacing: capture strobe at count 0, produce strobe half a period later.
   chip8_strobe_div #(.DIV(SAMPLE_DIV), .PULSE_AT(0)) u_sample_end (
      .clk     (clk),
      .reset_n (reset_n),
      .o_pulse (w_sample_end)
   );

   chip8_strobe_div #(.DIV(SAMPLE_DIV), .PULSE_AT(SAMPLE_DIV / 2)) u_sample_req (
      .clk     (clk),
      .reset_n (reset_n),
      .o_pulse (w_sample_req)
   );

   // 60 Hz timer tick.
   chip8_strobe_div #(.DIV(TICK_DIV), .PULSE_AT(TICK_DIV - 1)) u_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .o_pulse (w_tick)
   );

   // ST next value: CPU write beats the tick; decrement saturates at zero.
   always_comb begin
      w_st_nxt = r_st;
      if (bus.st_wr) begin
         w_st_nxt = bus.st_wdata;
      end else if (w_tick && (r_st != '0)) begin
         w_st_nxt = r_st - ST_W'(1);
      end
   end

   // ST register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_st <= '0;
      end else begin
         r_st <= w_st_nxt;
      end
   end

   // Phase tracks the datapath sine index, so it only moves while sine is enabled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_phase <= '0;
      end else if (w_sample_req && r_ctrl.sine) begin
         r_phase <= (r_phase == PW'(TABLE_LEN - 1)) ? '0 : r_phase + PW'(1);
      end
   end

   assign w_phase_zero = (r_phase == '0);

   // Tone FSM with registered control/tone_active; DRAIN exits only at a table wrap.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= IDLE;
         r_ctrl        <= '0;
         r_tone_active <= 1'b0;
      end else begin
         r_ctrl.rsvd     <= '0;
         r_ctrl.feedback <= w_loopback;
         case (r_state)
            IDLE: begin
               if (r_st != '0) begin
                  r_state       <= TONE;
                  r_ctrl.sine   <= ~w_loopback;
                  r_tone_active <= 1'b1;
               end else begin
                  r_ctrl.sine   <= 1'b0;
                  r_tone_active <= 1'b0;
               end
            end
            TONE: begin
               if (r_st == '0) begin
                  r_state <= DRAIN;
               end
               r_ctrl.sine   <= ~w_loopback;
               r_tone_active <= 1'b1;
            end
            DRAIN: begin
               if (r_st != '0) begin
                  r_state       <= TONE;
                  r_ctrl.sine   <= ~w_loopback;
                  r_tone_active <= 1'b1;
               end else if (w_phase_zero && !w_sample_req) begin
                  r_state       <= IDLE;
                  r_ctrl.sine   <= 1'b0;
                  r_tone_active <= 1'b0;
               end else begin
                  r_ctrl.sine   <= ~w_loopback;
                  r_tone_active <= 1'b1;
               end
            end
            default: begin
               r_state       <= IDLE;
               r_ctrl.sine   <= 1'b0;
               r_tone_active <= 1'b0;
            end
         endcase
      end
   end

   assign bus.st_value    = r_st;
   assign bus.control     = r_ctrl;
   assign bus.tone_active = r_tone_active;
   assign bus.sample_end  = w_sample_end;
   assign bus.sample_req  = w_sample_req;
   assign bus.tick_60hz   = w_tick;

endmodule

// File: tb/tb_chip8_sound_ctrl.sv
// Scoreboard bench for chip8_sound_ctrl at SAMPLE_DIV=8, TICK_DIV=64, TABLE_LEN=100.
// Define CHIP8_AUDIO_LOOPBACK_EN to also exercise the loopback input.
module tb_chip8_sound_ctrl;
   import chip8_audio_pkg::*;

   localparam int unsigned SDIV = 8;
   localparam int unsigned TDIV = 64;
   localparam int unsigned TLEN = 100;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
`ifdef CHIP8_AUDIO_LOOPBACK_EN
   logic loopback_en = 1'b0;
`endif

   chip8_sound_ctrl_if bus ();

   chip8_sound_ctrl #(
      .SAMPLE_DIV (SDIV),
      .TICK_DIV   (TDIV),
      .TABLE_LEN  (TLEN)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
`ifdef CHIP8_AUDIO_LOOPBACK_EN
      .loopback_en (loopback_en),
`endif
      .bus         (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, act, exp);
      end
   endtask

   // Scoreboard state: expected sample_req cycles and expected ST after each tick.
   int q_req[$];
   int q_st[$];
   int cyc       = 0;
   int last_se   = 0;
   int last_tick = 0;
   int se_count  = 0;
   int tb_phase  = 0;
   bit have_se   = 1'b0;
   bit have_tick = 1'b0;
   bit pend_st   = 1'b0;

   // Monitor on the falling edge: strobe spacing, tick spacing, ST after tick, phase model.
   always @(negedge clk) begin
      if (!reset_n) begin
         q_req.delete();
         q_st.delete();
         have_se   = 1'b0;
         have_tick = 1'b0;
         pend_st   = 1'b0;
         tb_phase  = 0;
      end else begin
         cyc++;
         if (bus.sample_end || bus.sample_req)
            chk("strobe_overlap", bus.sample_end & bus.sample_req, 0);
         if (bus.sample_end) begin
            if (have_se) chk("se_period", cyc - last_se, SDIV);
            last_se = cyc;
            have_se = 1'b1;
            se_count++;
            q_req.push_back(cyc + int'(SDIV / 2));
         end
         if (bus.sample_req && (q_req.size() != 0))
            chk("req_offset", cyc, q_req.pop_front());
         if (pend_st) begin
            chk("st_after_tick", bus.st_value, q_st.pop_front());
            pend_st = 1'b0;
         end
         if (bus.tick_60hz) begin
            if (have_tick) chk("tick_period", cyc - last_tick, TDIV);
            last_tick = cyc;
            have_tick = 1'b1;
            if (q_st.size() != 0) pend_st = 1'b1;
         end
         if (bus.sample_req && bus.control[0])
            tb_phase = (tb_phase + 1) % int'(TLEN);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic write_st(input logic [7:0] v);
      bus.st_wr    = 1'b1;
      bus.st_wdata = v;
      step();
      bus.st_wr    = 1'b0;
   endtask

   task automatic wait_tick(input string tag);
      int n = 0;
      while (!bus.tick_60hz && (n < int'(2 * TDIV))) begin
         step();
         n++;
      end
      chk(tag, bus.tick_60hz, 1);
   endtask

   task automatic sync_tick();
      wait_tick("sync_tick");
      step();
      step();
   endtask

   task automatic wait_ctrl(input logic [3:0] exp, input int budget, input string tag);
      int n = 0;
      while ((bus.control !== exp) && (n < budget)) begin
         step();
         n++;
      end
      chk(tag, bus.control, exp);
   endtask

   task automatic wait_st_zero(input int budget, input string tag);
      int n = 0;
      while ((bus.st_value != 8'd0) && (n < budget)) begin
         step();
         n++;
      end
      chk(tag, bus.st_value, 0);
   endtask

   task automatic wait_phase(input int p, input int budget, input string tag);
      int n = 0;
      while ((tb_phase != p) && (n < budget)) begin
         step();
         n++;
      end
      chk(tag, tb_phase, p);
   endtask

   task automatic wait_sb_empty(input int budget);
      int n = 0;
      while (((q_st.size() != 0) || pend_st) && (n < budget)) begin
         step();
         n++;
      end
      chk("sb_drain", q_st.size(), 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.st_wr    = 1'b0;
      bus.st_wdata = 8'd0;

      // Reset state and idle pacing.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ctrl", bus.control, 0);
      chk("rst_st", bus.st_value, 0);
      chk("rst_tone", bus.tone_active, 0);
      chk("rst_strobes", {bus.sample_end, bus.sample_req, bus.tick_60hz}, 0);
      step();
      reset_n = 1'b1;
      repeat (200) step();
      chk("idle_ctrl", bus.control, 0);
      chk("idle_st", bus.st_value, 0);
      chk("idle_se_seen", (se_count >= 24) ? 1 : 0, 1);

      // Write 3: two-cycle latency, countdown 2,1,0, drain to a phase wrap.
      sync_tick();
      q_st.push_back(2);
      q_st.push_back(1);
      q_st.push_back(0);
      write_st(8'd3);
      chk("lat1_st", bus.st_value, 3);
      chk("lat1_ctrl", bus.control, 0);
      step();
      chk("lat2_ctrl", bus.control, 1);
      chk("lat2_tone", bus.tone_active, 1);
      wait_sb_empty(4 * int'(TDIV));
      step();
      step();
      chk("drain_hold", bus.control, 1);
      chk("drain_tone", bus.tone_active, 1);
      wait_ctrl(4'd0, int'(TLEN * SDIV) + 40, "drain_end");
      chk("drain_phase", tb_phase, 0);
      chk("drain_tone_off", bus.tone_active, 0);

      // DRAIN at phase 57, write 5: back to TONE with no gap.
      sync_tick();
      write_st(8'd1);
      step();
      chk("t3_on", bus.control, 1);
      wait_st_zero(2 * int'(TDIV), "t3_st0");
      wait_phase(57, int'(TLEN * SDIV), "t3_phase57");
      chk("t3_drain", bus.control, 1);
      write_st(8'd5);
      chk("t3_st", bus.st_value, 5);
      chk("t3_ctrl_a", bus.control, 1);
      step();
      chk("t3_ctrl_b", bus.control, 1);
      chk("t3_state", dut.r_state, TONE);

      // Write 9 on the tick cycle: write wins, tick lost.
      wait_tick("t4_tick");
      q_st.push_back(9);
      write_st(8'd9);
      chk("t4_st", bus.st_value, 9);
      write_st(8'd0);
      wait_ctrl(4'd0, int'(TLEN * SDIV) + 40, "t4_drain_end");
      chk("phase_model", dut.r_phase, tb_phase);

      // Write 0 in IDLE has no effect.
      write_st(8'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("w0_ctrl", bus.control, 0);
         chk("w0_tone", bus.tone_active, 0);
         chk("w0_st", bus.st_value, 0);
      end

      // Asynchronous reset in the middle of a tone.
      sync_tick();
      write_st(8'd4);
      step();
      chk("t5_on", bus.control, 1);
      chk("t5_st", bus.st_value, 4);
      reset_n = 1'b0;
      #1;
      chk("t5_rst_ctrl", bus.control, 0);
      chk("t5_rst_st", bus.st_value, 0);
      chk("t5_rst_tone", bus.tone_active, 0);
      chk("t5_rst_strobes", {bus.sample_end, bus.sample_req, bus.tick_60hz}, 0);
      repeat (3) @(posedge clk);
      #2;
      reset_n = 1'b1;
      step();

`ifdef CHIP8_AUDIO_LOOPBACK_EN
      // Loopback: feedback selected, sine muted, phase frozen, resume afterwards.
      sync_tick();
      write_st(8'd2);
      step();
      chk("lb_on", bus.control, 1);
      repeat (5) step();
      loopback_en = 1'b1;
      step();
      chk("lb_ctrl", bus.control, 4'b0010);
      repeat (16) step();
      chk("lb_ctrl_hold", bus.control, 4'b0010);
      chk("lb_phase", dut.r_phase, tb_phase);
      loopback_en = 1'b0;
      step();
      chk("lb_resume", bus.control, 4'b0001);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
